// File: rtl/fmac_arb_pkg.sv
// Shared types and defaults for the FMAC arbiter slice.
// Holds the FSM state enum, the in-flight tag record and the default FMAC latency.
package fmac_arb_pkg;

  localparam int FMAC_DELAY_DEFAULT = 8;
  localparam int TAG_ID_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmac_tag_pipe.sv
// Fixed-latency tag pipeline mirroring the FMAC: each issued beat's owner id
// travels alongside the operation so the result can be routed back.
module fmac_tag_pipe
  import fmac_arb_pkg::*;
#(
  parameter int DEPTH = FMAC_DELAY_DEFAULT,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            tail_valid,
  output logic [ID_W-1:0] tail_id,
  output logic            any_valid
);

  tag_t stage_r [DEPTH];

  // Shift every cycle; reset invalidates everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= '{valid: in_valid, id: TAG_ID_W'(in_id)};
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tail_valid = stage_r[DEPTH-1].valid;
  assign tail_id    = stage_r[DEPTH-1].id[ID_W-1:0];

  // Any beat still inside the FMAC keeps the arbiter busy.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_r[i].valid;
    end
  end

endmodule

// File: rtl/fmac_arbiter.sv
// Round-robin, burst-locking arbiter sharing one fixed-latency axis_fmac among NREQ requesters.
// Optional consistency checker on the FMAC return path: define FMAC_ARB_CHECK_EN.
module fmac_arbiter
  import fmac_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FMAC_DELAY = FMAC_DELAY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][31:0] req_c,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [31:0]           res_tdata,
  output logic [NREQ-1:0]       res_tvalid,
  output logic [31:0]           fmac_a,
  output logic [31:0]           fmac_b,
  output logic [31:0]           fmac_c,
  output logic                  fmac_valid,
  input  logic [31:0]           fmac_out_tdata,
  input  logic                  fmac_out_tvalid,
  output logic                  busy,
  output logic                  err
);

  localparam int ID_W = id_width(NREQ);

  state_e          state_r;
  logic [ID_W-1:0] owner_r;
  logic [ID_W-1:0] rr_ptr_r;
  logic            grant_s;
  logic [ID_W-1:0] grant_id_s;
  logic [ID_W-1:0] next_ptr_s;
  logic            tail_valid_s;
  logic [ID_W-1:0] tail_id_s;
  logic            any_tag_s;

  // Pick the single requester allowed to issue this cycle.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_s    = 1'b0;
    grant_id_s = '0;
    cand       = '0;
    if (rst) begin
      grant_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      grant_s    = req_valid[owner_r];
      grant_id_s = owner_r;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cand = ID_W'((int'(rr_ptr_r) + i) % NREQ);
        if (!grant_s && req_valid[cand]) begin
          grant_s    = 1'b1;
          grant_id_s = cand;
        end else begin
          grant_s = grant_s;
        end
      end
    end
  end

  // Ready is the one-hot grant; acceptance therefore coincides with grant_s.
  always_comb begin
    req_ready = '0;
    if (grant_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign fmac_valid = grant_s;
  assign fmac_a     = req_a[grant_id_s];
  assign fmac_b     = req_b[grant_id_s];
  assign fmac_c     = req_c[grant_id_s];
  assign next_ptr_s = (int'(grant_id_s) == NREQ - 1) ? '0 : grant_id_s + ID_W'(1);

  // Burst lock FSM and round-robin pointer; the pointer only moves on a final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      if (req_last[grant_id_s]) begin
        state_r  <= ST_IDLE;
        rr_ptr_r <= next_ptr_s;
      end else begin
        state_r <= ST_LOCKED;
        owner_r <= grant_id_s;
      end
    end else begin
      state_r <= state_r;
    end
  end

  fmac_tag_pipe #(
    .DEPTH (FMAC_DELAY),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (grant_s),
    .in_id      (grant_id_s),
    .tail_valid (tail_valid_s),
    .tail_id    (tail_id_s),
    .any_valid  (any_tag_s)
  );

  // Route a returning result to its owner; results of beats issued before a reset have no tag and are dropped.
  always_comb begin
    res_tvalid = '0;
    if (!rst && fmac_out_tvalid && tail_valid_s) begin
      res_tvalid[tail_id_s] = 1'b1;
    end else begin
      res_tvalid = '0;
    end
  end

  assign res_tdata = fmac_out_tdata;
  assign busy      = (state_r == ST_LOCKED) || any_tag_s;

`ifdef FMAC_ARB_CHECK_EN
  localparam int CNT_W = $clog2(FMAC_DELAY + 1);

  logic [CNT_W-1:0] quiet_cnt_r;
  logic             err_r;

  // Sticky return-path mismatch flag, silent until pre-reset beats have drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet_cnt_r <= CNT_W'(FMAC_DELAY);
      err_r       <= 1'b0;
    end else if (quiet_cnt_r != '0) begin
      quiet_cnt_r <= quiet_cnt_r - CNT_W'(1);
    end else if (fmac_out_tvalid != tail_valid_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fmac_arbiter.sv
// Self-checking bench for fmac_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a stand-in fixed-latency FMAC.
module tb_fmac_arbiter;

  localparam int NREQ = 2;
  localparam int DLY  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0][31:0] req_a, req_b, req_c;
  logic [NREQ-1:0]       req_valid, req_last, req_ready;
  logic [31:0]           res_tdata;
  logic [NREQ-1:0]       res_tvalid;
  logic [31:0]           fmac_a, fmac_b, fmac_c;
  logic                  fmac_valid;
  logic [31:0]           fmac_out_tdata;
  logic                  fmac_out_tvalid;
  logic                  busy, err;

  always #5 clk = ~clk;

  fmac_arbiter #(.NREQ(NREQ), .FMAC_DELAY(DLY)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid),
    .fmac_a(fmac_a), .fmac_b(fmac_b), .fmac_c(fmac_c), .fmac_valid(fmac_valid),
    .fmac_out_tdata(fmac_out_tdata), .fmac_out_tvalid(fmac_out_tvalid),
    .busy(busy), .err(err)
  );

  // Stand-in FMAC: exact for the reference triple, integer a*b+c otherwise.
  function automatic logic [31:0] fmac_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000) return 32'h40E00000;
    return a * b + c;
  endfunction

  logic        fp_v [DLY];
  logic [31:0] fp_d [DLY];
  logic        inject;

  // The FMAC is not reset, so results of pre-reset beats still emerge.
  always @(posedge clk) begin
    fp_v[0] <= fmac_valid;
    fp_d[0] <= fmac_fn(fmac_a, fmac_b, fmac_c);
    for (int i = 1; i < DLY; i++) begin
      fp_v[i] <= fp_v[i-1];
      fp_d[i] <= fp_d[i-1];
    end
  end

  assign fmac_out_tvalid = fp_v[DLY-1] | inject;
  assign fmac_out_tdata  = fp_d[DLY-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          checks, errors, cyc;
  int          m_rr, m_owner;
  bit          m_locked;
  logic        exp_err;
  int          obs_g;
  logic [1:0]  obs_rv;
  logic [31:0] obs_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT outputs with the model, then advance the model.
  task automatic step();
    int         g;
    logic       gi;
    logic [1:0] exp_acc, exp_rv;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (g < 0 && req_valid[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
        end
      end
    end
    obs_g = -1;
    for (int k = 0; k < NREQ; k++) if (req_ready[k] && req_valid[k]) obs_g = k;
    obs_rv = res_tvalid;
    obs_rd = res_tdata;
    exp_acc = (g >= 0) ? (2'b01 << g) : 2'b00;
    chk("grant", req_ready & req_valid, exp_acc);
    chk("ready_onehot", ($countones(req_ready) <= 1), 1);
    chk("fmac_valid", fmac_valid, (g >= 0));
    if (g >= 0) begin
      gi = g[0];
      chk("fmac_a", fmac_a, req_a[gi]);
      chk("fmac_b", fmac_b, req_b[gi]);
      chk("fmac_c", fmac_c, req_c[gi]);
    end
    exp_rv = 2'b00;
    if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
      exp_rv = 2'b01 << mq[0].id;
      chk("res_tdata", res_tdata, mq[0].d);
    end
    chk("res_tvalid", res_tvalid, exp_rv);
    if (!rst) chk("busy", busy, (m_locked || mq.size() > 0));
    chk("err", err, exp_err);
    if (mq.size() > 0 && mq[0].due == cyc) void'(mq.pop_front());
    if (rst) begin
      mq.delete();
      m_locked = 0;
      m_rr     = 0;
    end else if (g >= 0) begin
      mq.push_back('{due: cyc + DLY, id: g, d: fmac_fn(req_a[gi], req_b[gi], req_c[gi])});
      if (req_last[gi]) begin
        m_locked = 0;
        m_rr     = (g + 1) % NREQ;
      end else begin
        m_locked = 1;
        m_owner  = g;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++) begin
      req_a[k] = $urandom;
      req_b[k] = $urandom;
      req_c[k] = $urandom;
    end
  endtask

  initial begin
    int issue_cyc, lat, b1;
    int glog[$];
    checks = 0; errors = 0; cyc = 0;
    m_rr = 0; m_owner = 0; m_locked = 0;
    exp_err = 1'b0; inject = 1'b0;
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    req_valid = 2'b11; req_last = 2'b11;
    @(posedge clk);
    #1;
    repeat (10) step();
    rst = 1'b0;
    req_valid = 2'b00;
    step();
    chk("reset_busy", busy, 1'b0);

    // Single beat from requester 0 with an 8-cycle result
    req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_c[0] = 32'h3F800000;
    req_valid = 2'b01; req_last = 2'b01;
    step();
    chk("034_issue", obs_g, 0);
    issue_cyc = cyc - 1;
    req_valid = 2'b00;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_rv != 2'b00 && lat < 0) begin
        lat = cyc - 1 - issue_cyc;
        chk("034_owner", obs_rv, 2'b01);
        chk("034_data", obs_rd, 32'h40E00000);
      end
    end
    chk("034_latency", lat, 8);

    // Both requesters single-beat, grants alternate from 0
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b11; req_last = 2'b11;
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
      glog.push_back(obs_g);
    end
    for (int i = 0; i < 8; i++) chk("035_alternate", glog[i], i % 2);
    req_valid = 2'b00;
    repeat (10) step();

    // Requester 1 bursts four beats while requester 0 waits
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b01; req_last = 2'b01;
    step();
    req_valid = 2'b11;
    b1 = 0;
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      req_last = {(b1 == 3), 1'b1};
      step();
      glog.push_back(obs_g);
      if (obs_g == 1) b1++;
    end
    for (int i = 0; i < 4; i++) chk("036_burst", glog[i], 1);
    chk("036_after", glog[4], 0);
    req_valid = 2'b00;
    repeat (10) step();

    // Owner pauses mid-burst; lock holds with no timeout
    req_valid = 2'b01; req_last = 2'b00;
    step();
    req_valid = 2'b10; req_last = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("018_hold", obs_g, -1);
    end
    req_valid = 2'b11; req_last = 2'b11;
    step();
    chk("018_owner_last", obs_g, 0);
    step();
    chk("018_release", obs_g, 1);
    req_valid = 2'b00;
    repeat (10) step();

    // Reset three cycles after issue drops the result
    req_valid = 2'b01; req_last = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (2) step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("037_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("037_nores", obs_rv, 2'b00);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_ops();
      req_valid = 2'($urandom_range(0, 3));
      req_last  = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (12) step();

    // Spurious FMAC result with no tag in flight
    inject = 1'b1;
    step();
    inject = 1'b0;
`ifdef FMAC_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    exp_err = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
